// File: rtl/ascon_permutation_core.sv
// Iterative Ascon-p permutation engine: 6/8/12 rounds, UNROLL rounds per clock.
// Optional RUN-cycle counter enabled by defining ASCON_PERM_CYCLE_CNT_EN.
module ascon_permutation_core #(
  parameter int UNROLL = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       rounds_i,
  input  logic [4:0][63:0] state_i,
  output logic [4:0][63:0] state_o,
  output logic             update_state_o,
  output logic             finished_o,
  output logic             busy_o
`ifdef ASCON_PERM_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, WAIT_CLR} fsm_e;

  localparam logic [3:0] STEP = 4'(UNROLL);

  fsm_e             fsm_r;
  logic [4:0][63:0] state_r;
  logic [3:0]       rc_r;
  logic [3:0]       nr_r;
  logic [3:0]       nr_sel_s;
  logic [4:0][63:0] round_out_s;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One full Ascon round for constant index idx; word k of s is xk.
  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                   input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    c  = {4'd15 - idx, idx};
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, c};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    return {x4 ^ rotr(x4, 7)  ^ rotr(x4, 41),
            x3 ^ rotr(x3, 10) ^ rotr(x3, 17),
            x2 ^ rotr(x2, 1)  ^ rotr(x2, 6),
            x1 ^ rotr(x1, 61) ^ rotr(x1, 39),
            x0 ^ rotr(x0, 19) ^ rotr(x0, 28)};
  endfunction

  // Illegal round counts fall back to the full 12-round permutation.
  always_comb begin
    nr_sel_s = 4'd12;
    case (rounds_i)
      4'd6:    nr_sel_s = 4'd6;
      4'd8:    nr_sel_s = 4'd8;
      default: nr_sel_s = 4'd12;
    endcase
  end

  // Datapath for one clock: UNROLL consecutive rounds starting at index 12-nr+rc.
  always_comb begin
    round_out_s = state_r;
    for (int u = 0; u < UNROLL; u++) begin
      round_out_s = ascon_round(round_out_s, 4'd12 - nr_r + rc_r + 4'(u));
    end
  end

  // Control FSM, working state register and registered status pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_r          <= IDLE;
      state_r        <= '0;
      rc_r           <= 4'd0;
      nr_r           <= 4'd12;
      update_state_o <= 1'b0;
      finished_o     <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      update_state_o <= 1'b0;
      finished_o     <= 1'b0;
      case (fsm_r)
        IDLE: begin
          if (start_i) begin
            state_r <= state_i;
            nr_r    <= nr_sel_s;
            rc_r    <= 4'd0;
            busy_o  <= 1'b1;
            fsm_r   <= RUN;
          end
        end
        RUN: begin
          state_r <= round_out_s;
          rc_r    <= rc_r + STEP;
          if (rc_r + STEP == nr_r) begin
            update_state_o <= 1'b1;
            finished_o     <= 1'b1;
            fsm_r          <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          fsm_r  <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!start_i) begin
            fsm_r <= IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          fsm_r  <= IDLE;
        end
      endcase
    end
  end

  assign state_o = state_r;

`ifdef ASCON_PERM_CYCLE_CNT_EN
  logic [CNT_W-1:0] perf_r;

  // Saturating count of RUN cycles for the most recent operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_r <= '0;
    end else if (fsm_r == IDLE && start_i) begin
      perf_r <= '0;
    end else if (fsm_r == RUN && perf_r != '1) begin
      perf_r <= perf_r + CNT_W'(1);
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_cycles_o = perf_r;
`endif

endmodule

// File: tb/tb_ascon_permutation_core.sv
// Directed/random bench for ascon_permutation_core against a table-driven Ascon-p model.
// Checks the perf counter too when ASCON_PERM_CYCLE_CNT_EN is defined.
module tb_ascon_permutation_core;

  typedef logic [4:0][63:0] st_t;

  localparam int UNROLL = 1;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [3:0] rounds_i;
  st_t        state_i;
  st_t        state_o;
  logic       update_state_o;
  logic       finished_o;
  logic       busy_o;
`ifdef ASCON_PERM_CYCLE_CNT_EN
  logic [15:0] perf_cycles_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int fin_cnt  = 0;

  ascon_permutation_core #(.UNROLL(UNROLL), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .rounds_i       (rounds_i),
    .state_i        (state_i),
    .state_o        (state_o),
    .update_state_o (update_state_o),
    .finished_o     (finished_o),
    .busy_o         (busy_o)
`ifdef ASCON_PERM_CYCLE_CNT_EN
    ,
    .perf_cycles_o  (perf_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (finished_o) fin_cnt++;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference: constant add, S-box lookup per bit column, then linear layer.
  function automatic st_t model_perm(input st_t s, input int nr);
    st_t        x;
    st_t        y;
    logic [4:0] v;
    logic [4:0] o;
    int         i;
    x = s;
    for (int r = 0; r < nr; r++) begin
      i = 12 - nr + r;
      x[2] = x[2] ^ 64'(((15 - i) << 4) | i);
      y = '0;
      for (int j = 0; j < 64; j++) begin
        v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        o = SBOX[v];
        y[0][j] = o[4];
        y[1][j] = o[3];
        y[2][j] = o[2];
        y[3][j] = o[1];
        y[4][j] = o[0];
      end
      for (int w = 0; w < 5; w++) x[w] = y[w] ^ rotr(y[w], ROT_A[w]) ^ rotr(y[w], ROT_B[w]);
    end
    return x;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from IDLE; call at a negedge with start_i low.
  task automatic run_op(input st_t st, input logic [3:0] rnds, input bit disturb, input bit hold);
    int  exp_nr;
    int  cyc;
    bit  got;
    int  f0;
    st_t exp;
    exp_nr   = (rnds == 4'd6) ? 6 : (rnds == 4'd8) ? 8 : 12;
    exp      = model_perm(st, exp_nr);
    state_i  = st;
    rounds_i = rnds;
    start_i  = 1'b1;
    @(posedge clk);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 3) begin
        start_i  = 1'b0;
        state_i  = rand_state();
        rounds_i = 4'($urandom_range(0, 15));
      end
      if (finished_o) got = 1'b1;
    end
    chk("latency", 320'(cyc), 320'(exp_nr / UNROLL + 1));
    chk("result", state_o, exp);
    chk("update_pulse", 320'(update_state_o), 320'd1);
    chk("busy_done", 320'(busy_o), 320'd1);
`ifdef ASCON_PERM_CYCLE_CNT_EN
    chk("perf_cycles", 320'(perf_cycles_o), 320'(exp_nr / UNROLL));
`endif
    @(negedge clk);
    chk("finished_one_cycle", 320'({finished_o, update_state_o}), 320'd0);
    chk("busy_after", 320'(busy_o), 320'd0);
    chk("result_hold", state_o, exp);
    if (hold) begin
      f0 = fin_cnt;
      repeat (6) @(negedge clk);
      chk("no_retrigger_pulse", 320'(fin_cnt - f0), 320'd0);
      chk("no_retrigger_busy", 320'(busy_o), 320'd0);
      chk("no_retrigger_state", state_o, exp);
    end
    start_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [3:0] rsel;
  int         f_before;

  initial begin
    rst_i    = 1'b1;
    start_i  = 1'b0;
    rounds_i = 4'd12;
    state_i  = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", state_o, '0);
    chk("reset_flags", 320'({finished_o, update_state_o, busy_o}), 320'd0);
    rst_i = 1'b0;
    @(negedge clk);

    run_op('0, 4'd12, 1'b0, 1'b1);
    run_op(rand_state(), 4'd6, 1'b0, 1'b0);
    run_op(rand_state(), 4'd8, 1'b0, 1'b0);
    run_op(rand_state(), 4'd5, 1'b0, 1'b0);
    run_op(rand_state(), 4'd12, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rsel = 4'($urandom_range(0, 15));
      run_op(rand_state(), rsel, 1'b0, ($urandom_range(0, 1) == 1));
    end

    // Asynchronous reset in the middle of a run.
    state_i  = rand_state();
    rounds_i = 4'd12;
    start_i  = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_state", state_o, '0);
    chk("async_rst_flags", 320'({finished_o, update_state_o, busy_o}), 320'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    f_before = fin_cnt;
    repeat (20) @(negedge clk);
    #1;
    chk("no_pulse_after_rst", 320'(fin_cnt - f_before), 320'd0);
    chk("idle_after_rst", 320'({busy_o, state_o}), 320'd0);

    run_op(rand_state(), 4'd8, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_permutation_core.md
Name: ascon_permutation_core

Overview:
Iterative Ascon-p permutation engine that sits directly downstream of the ASCON register file. It consumes the 320-bit state and the start level from the register block, and applies 6, 8 or 12 Ascon rounds. It returns the permuted state together with a one-cycle update/finished pulse, which writes the result back and clears start. Each round performs constant addition, the bitsliced 5-bit S-box and linear diffusion.

Parameters:
UNROLL, 1, rounds computed per clock; legal values 1 or 2 (both divide 6, 8 and 12).
CNT_W, 16, width of the optional cycle counter.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; asynchronous, active-high
start_i  input  1  start level from register block (status.q)
rounds_i  input  4  round count; 6, 8 or 12, any other value treated as 12
state_i  input  5x64  input state words x0..x4
state_o  output  5x64  working/result state x0..x4
update_state_o  output  1  one-cycle pulse; register block captures state_o
finished_o  output  1  one-cycle pulse, coincident with update_state_o
busy_o  output  1  high in LOAD-accepted RUN and DONE states

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE; state register=0; round counter=0; nr=12; all pulse outputs 0; busy_o=0; state_o=0.
- FSM states: IDLE, RUN, DONE, WAIT_CLR.
- IDLE, start_i=1 at clock edge:
  - load state register <= state_i.
  - nr <= rounds_i (or 12 if illegal).
  - rc <= 0.
  - go to RUN.
- IDLE, start_i=0: hold; state_o keeps the last result.
- RUN: each edge applies UNROLL rounds and rc += UNROLL. When rc+UNROLL == nr, go to DONE.
- Round r of nr uses constant index i = 12 - nr + r, with constant c = ((15-i)<<4) | i (0xf0, 0xe1, ..., 0x4b).
- Round function:
  - x2 ^= c.
  - Ascon S-box bitsliced across the 64 bit positions.
  - Linear layer, with rotate right by (a, b) per word: x0 (19, 28), x1 (61, 39), x2 (1, 6), x3 (10, 17), x4 (7, 41). Each word becomes x ^ rotr(x, a) ^ rotr(x, b).
- DONE (exactly one cycle): update_state_o=1, finished_o=1, and state_o holds the final state. Next state: WAIT_CLR.
- WAIT_CLR: hold result. Return to IDLE when start_i=0; no re-trigger while start_i stays high.
- Latency: finished_o asserts nr/UNROLL + 1 cycles after the load edge. For 12 rounds with UNROLL=1, that is 13 cycles.
- Changes on state_i or rounds_i after the load edge are ignored until the next IDLE.
- start_i falling during RUN: ignored; the permutation completes and DONE still pulses.
- busy_o=1 in RUN and DONE, 0 in IDLE and WAIT_CLR.
- Reset mid-RUN: immediate return to reset values; no finished_o pulse is emitted.
- state_o is driven directly from the working register, so it shows intermediate rounds during RUN. Consumers sample state_o only when update_state_o=1.

Optional Feature:
Macro ASCON_PERM_CYCLE_CNT_EN.
- Defined:
  - Adds output perf_cycles_o [CNT_W-1:0], which counts the cycles spent in RUN for the last operation.
  - It is cleared on the load edge, increments each RUN cycle, saturates at all-ones and holds through DONE/WAIT_CLR/IDLE.
  - Reset value is 0.
- Not defined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset asserted asynchronously mid-cycle -> all outputs 0 immediately, FSM in IDLE, no pulse after release.
- state_i=all zeros, rounds_i=12, UNROLL=1, start_i=1 -> finished_o and update_state_o high for exactly 1 cycle, 13 cycles after the load edge. state_o matches the golden Ascon-p12 model output for the zero state.
- rounds_i=6 and rounds_i=8 with a random state -> latency of 7 and 9 cycles respectively. Results match the model's p6/p8 using constants 0x96..0x4b and 0xb4..0x4b.
- rounds_i=5 -> treated as 12: latency 13, result equals the p12 model.
- start_i held high after DONE -> no second operation. Drop start_i, raise again with a new state -> a new run completes correctly.
- start_i deasserted during RUN, plus state_i changed mid-RUN -> result equals the permutation of the originally loaded state, and DONE still pulses. With ASCON_PERM_CYCLE_CNT_EN defined, perf_cycles_o=12 after p12.
